instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of program_counter. Takes the PC value each

---
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage sitting between program_counter and decode.
// Issues one ROM read per cycle at the current PC. Buffers returned {pc, inst}
// pairs in a small FIFO for the decoder. Drives program_counter's load/data
// inputs to hold the PC when the buffer would overflow, or to redirect it on
// jumps.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   pc_in            current program_counter value
//   pc_load/pc_data  load request back into program_counter (combinational)
//   rom_addr         ROM read address (= pc_in); ROM answers one cycle later
//   rom_data         ROM data for the address presented on the previous cycle
//   inst_valid/inst/inst_pc/inst_ready
//                    FIFO head and valid/ready handshake to the decoder
//   jump_valid/jump_target
//                    redirect request from the execute stage
module instruction_fetch #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_data,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_target
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state_c;
  logic [WIDTH-1:0] mem_pc   [DEPTH];
  logic [WIDTH-1:0] mem_inst [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             req_v;
  logic [WIDTH-1:0] req_pc;
  logic             pop_c;
  logic [CW:0]      occupancy_c;
  logic             issue_ok_c;

  assign rom_addr   = pc_in;
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign pop_c      = inst_valid & inst_ready;

  // Entries held next cycle if we issue now; issuing is safe only if the
  // resulting push one cycle later still has room even without a pop.
  assign occupancy_c = (CW+1)'(count) + (CW+1)'(req_v) - (CW+1)'(pop_c);
  assign issue_ok_c  = occupancy_c < (CW+1)'(DEPTH);

  // State carries no memory: it is a decode of the current occupancy.
  always_comb begin
    state_c = RUN;
    if (!issue_ok_c) state_c = STALL;
  end

  // PC control: jump beats stall; reset forces the idle values.
  always_comb begin
    pc_load = 1'b0;
    pc_data = '0;
    if (!reset) begin
      if (jump_valid) begin
        pc_load = 1'b1;
        pc_data = jump_target;
      end else if (state_c == STALL) begin
        pc_load = 1'b1;
        pc_data = pc_in;
      end
    end
  end

  // Request tracking and FIFO storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_v  <= 1'b0;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (jump_valid) begin
      // Flush: queued entries and the in-flight read are stale.
      req_v  <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      req_v <= (state_c == RUN);
      if (state_c == RUN) req_pc <= pc_in;

      if (req_v) begin
        mem_pc[wr_ptr]   <= req_pc;
        mem_inst[wr_ptr] <= rom_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);

      case ({req_v, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models program_counter and a 1-cycle ROM with
// ROM[a] = a ^ 16'hA5A5. Expected deliveries are queued by the stimulus and
// popped and compared by a monitor whenever the decoder accepts an entry.
module tb_instruction_fetch;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pc_in;
  logic         pc_load;
  logic [W-1:0] pc_data;
  logic [W-1:0] rom_addr;
  logic [W-1:0] rom_data;
  logic         inst_valid;
  logic [W-1:0] inst;
  logic [W-1:0] inst_pc;
  logic         inst_ready;
  logic         jump_valid;
  logic [W-1:0] jump_target;

  logic [W-1:0] pc;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] next_pc;
  int           checks;
  int           errors;

  always #5 clk = ~clk;

  instruction_fetch #(.WIDTH(W), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .pc_data     (pc_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target)
  );

  // program_counter model
  always_ff @(posedge clk) begin
    if (reset)        pc <= '0;
    else if (pc_load) pc <= pc_data;
    else              pc <= pc + 16'd1;
  end
  assign pc_in = pc;

  // synchronous ROM model
  always_ff @(posedge clk) rom_data <= rom_addr ^ 16'hA5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n);
    repeat (n) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 16'd1;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      step();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d entries still expected after %0d cycles", name, exp_q.size(), t);
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !jump_valid && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected delivery: got inst_pc %h expected none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", 32'(inst_pc), 32'(e));
          chk("inst", 32'(inst), 32'(e ^ 16'hA5A5));
        end
      end
    end
  endtask

  task automatic stimulus();
    // reset state
    reset = 1'b1; inst_ready = 1'b0; jump_valid = 1'b0; jump_target = '0;
    next_pc = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst inst_valid", 32'(inst_valid), 32'd0);
    chk("rst pc_load", 32'(pc_load), 32'd0);
    chk("rst pc_data", 32'(pc_data), 32'd0);
    step();

    // 1: stream from 0, first delivery two cycles after reset falls
    reset = 1'b0; inst_ready = 1'b1;
    push_exp(12);
    @(negedge clk); chk("lat c0 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); chk("lat c1 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); chk("lat c2 valid", 32'(inst_valid), 32'd1);
    chk("lat c2 inst_pc", 32'(inst_pc), 32'd0);
    wait_drain("stream");

    // 2: backpressure; head = next_pc, PC held two ahead of it
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall pc_load", 32'(pc_load), 32'd1);
      chk("stall pc_data", 32'(pc_data), 32'(next_pc + 16'd2));
      chk("stall head", 32'(inst_pc), 32'(next_pc));
      chk("stall valid", 32'(inst_valid), 32'd1);
      step();
    end
    inst_ready = 1'b1;
    push_exp(8);
    wait_drain("release");

    // 3: jump while streaming (entry queued + read in flight)
    jump_valid = 1'b1; jump_target = 16'h0040;
    @(negedge clk);
    chk("jump pc_load", 32'(pc_load), 32'd1);
    chk("jump pc_data", 32'(pc_data), 32'h0040);
    step();
    jump_valid = 1'b0;
    @(negedge clk);
    chk("jump flush valid", 32'(inst_valid), 32'd0);
    next_pc = 16'h0040;
    push_exp(6);
    wait_drain("jump");

    // 4+5: jump into a full FIFO with ready low, target near wraparound
    inst_ready = 1'b0;
    repeat (4) step();
    jump_valid = 1'b1; jump_target = 16'hFFFE;
    @(negedge clk);
    chk("fulljump valid", 32'(inst_valid), 32'd1);
    chk("fulljump pc_load", 32'(pc_load), 32'd1);
    chk("fulljump pc_data", 32'(pc_data), 32'hFFFE);
    step();
    jump_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("fulljump flush valid", 32'(inst_valid), 32'd0);
    next_pc = 16'hFFFE;
    push_exp(6);
    wait_drain("wrap");

    // 6: reset mid-stream, also overriding a simultaneous jump
    reset = 1'b1; jump_valid = 1'b1; jump_target = 16'h1234;
    @(negedge clk);
    chk("rst+jump pc_load", 32'(pc_load), 32'd0);
    step();
    reset = 1'b0; jump_valid = 1'b0;
    @(negedge clk);
    chk("midrst valid", 32'(inst_valid), 32'd0);
    chk("midrst pc_load", 32'(pc_load), 32'd0);
    chk("midrst pc_data", 32'(pc_data), 32'd0);
    @(negedge clk);
    chk("midrst c1 valid", 32'(inst_valid), 32'd0);
    next_pc = '0;
    push_exp(5);
    wait_drain("refetch");
    inst_ready = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
